// File: rtl/inst_queue_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : inst_queue_if                                           |
// | Description : Fetch-side and decode-side signals of the inst queue.   |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
interface inst_queue_if #(
  parameter int DEPTH = 16
) ();
  localparam int c_CW = $clog2(DEPTH) + 1;

  logic             flush_i;
  logic [127:0]     fb_i;
  logic [127:0]     fb_addr_i;
  logic [3:0]       fb_en_i;
  logic             full_o;
  logic [63:0]      inst_o;
  logic [63:0]      inst_addr_o;
  logic [1:0]       inst_c_o;
  logic [1:0]       valid_o;
  logic [1:0]       deq_cnt_i;
  logic [c_CW-1:0]  count_o;
  logic             ovf_o;

  modport slave (
    input  flush_i, fb_i, fb_addr_i, fb_en_i, deq_cnt_i,
    output full_o, inst_o, inst_addr_o, inst_c_o, valid_o, count_o, ovf_o
  );

  modport master (
    output flush_i, fb_i, fb_addr_i, fb_en_i, deq_cnt_i,
    input  full_o, inst_o, inst_addr_o, inst_c_o, valid_o, count_o, ovf_o
  );
endinterface
`default_nettype wire

// File: rtl/inst_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : inst_queue                                              |
// | Description : 4-in / 2-out circular instruction queue between fetch   |
// |               and decode, with early full flag and jump flush.        |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module inst_queue #(
  parameter int DEPTH = 16,
  parameter int SKID  = 8
) (
  input  wire            clk,
  input  wire            rst,
  inst_queue_if.slave    bus
);
  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;

  logic [31:0]     r_inst [DEPTH];
  logic [31:0]     r_addr [DEPTH];
  logic [c_AW-1:0] r_head;
  logic [c_AW-1:0] r_tail;
  logic [c_CW-1:0] r_count;
  logic            r_ovf;

  logic [2:0]      w_enq_req;
  logic [c_CW-1:0] w_enq_req_x;
  logic [c_CW-1:0] w_deq_req;
  logic [c_CW-1:0] w_deq;
  logic [c_CW-1:0] w_cap;
  logic [c_CW-1:0] w_enq;
  logic            w_ovf;

  // Only the contiguous run of valid slots starting at slot 0 is accepted.
  always_comb begin
    w_enq_req = 3'd0;
    if (bus.fb_en_i[0])            w_enq_req = 3'd1;
    if (bus.fb_en_i[1:0] == 2'b11) w_enq_req = 3'd2;
    if (bus.fb_en_i[2:0] == 3'b111) w_enq_req = 3'd3;
    if (bus.fb_en_i == 4'b1111)    w_enq_req = 3'd4;
  end

  assign w_enq_req_x = c_CW'(w_enq_req);
  assign w_deq_req   = c_CW'(bus.deq_cnt_i);
  assign w_deq       = (w_deq_req > r_count) ? r_count : w_deq_req;
  assign w_cap       = c_CW'(DEPTH) - r_count + w_deq;
  assign w_enq       = (w_enq_req_x > w_cap) ? w_cap : w_enq_req_x;
  assign w_ovf       = (w_enq_req_x > w_cap);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (bus.flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + w_deq[c_AW-1:0];
      r_tail  <= r_tail + w_enq[c_AW-1:0];
      r_count <= r_count - w_deq + w_enq;
      if (w_ovf) r_ovf <= 1'b1;
    end
  end

  // Storage is not reset; lanes are masked by valid so stale data never leaks.
  always_ff @(posedge clk) begin
    if (!rst && !bus.flush_i) begin
      for (int k = 0; k < 4; k++) begin
        if (c_CW'(k) < w_enq) begin
          r_inst[r_tail + c_AW'(k)] <= bus.fb_i[32*k +: 32];
          r_addr[r_tail + c_AW'(k)] <= bus.fb_addr_i[32*k +: 32];
        end
      end
    end
  end

  logic [63:0] w_inst_o;
  logic [63:0] w_addr_o;
  logic [1:0]  w_valid_o;
  logic [1:0]  w_c_o;

  for (genvar k = 0; k < 2; k++) begin : g_lane
    logic [c_AW-1:0] w_idx;
    logic            w_valid;
    logic [31:0]     w_inst;

    assign w_idx   = r_head + c_AW'(k);
    assign w_valid = (r_count > c_CW'(k));
    assign w_inst  = w_valid ? r_inst[w_idx] : 32'd0;

    assign w_inst_o[32*k +: 32] = w_inst;
    assign w_addr_o[32*k +: 32] = w_valid ? r_addr[w_idx] : 32'd0;
    assign w_valid_o[k]         = w_valid;
    assign w_c_o[k]             = w_valid && (w_inst[1:0] != 2'b11);
  end

  assign bus.inst_o      = w_inst_o;
  assign bus.inst_addr_o = w_addr_o;
  assign bus.valid_o     = w_valid_o;
  assign bus.inst_c_o    = w_c_o;
  assign bus.count_o     = r_count;
  assign bus.ovf_o       = r_ovf;
  // Raised while fewer than SKID slots are free, leaving room for in-flight returns.
  assign bus.full_o      = ((c_CW'(DEPTH) - r_count) < c_CW'(SKID));
endmodule
`default_nettype wire

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Multi-entry instruction queue directly downstream of the fetch/PC stage.
- Each cycle it accepts up to 4 packed fetch-buffer entries (instruction + address) and presents up to 2 oldest entries in order to decode.
- Drives the fetch stage's full flag early enough to absorb instructions already in flight.
- Flushes on a jump.

Parameters:
- DEPTH, 16, number of queue entries; power of 2, at least 8.
- SKID, 8, free slots reserved for in-flight fetch returns; at least 4 and less than DEPTH.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- flush_i  in  1  jump flush; same signal as the fetch stage's jump flag
- fb_i  in  128  4 instruction slots; slot k at [32k+31:32k]; 16-bit instructions zero-extended
- fb_addr_i  in  128  4 addresses; slot k at [32k+31:32k]
- fb_en_i  in  4  slot valid, bit k for slot k
- full_o  out  1  to fetch full_flag_i; stop issuing fetches
- inst_o  out  64  2 output lanes; lane k at [32k+31:32k]
- inst_addr_o  out  64  lane addresses
- inst_c_o  out  2  lane holds a compressed instruction (bits[1:0] != 2'b11)
- valid_o  out  2  lane valid; always contiguous from lane 0
- deq_cnt_i  in  2  lanes consumed by decode this cycle (0..2)
- count_o  out  log2(DEPTH)+1  current occupancy
- ovf_o  out  1  sticky overflow error

Behaviour:
- Storage: circular buffer of DEPTH x {32-bit inst, 32-bit addr}. Head/tail pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is a separate register.
- Reset (rst=1 at posedge):
  - head = tail = count = 0; ovf_o = 0; full_o = 0; valid_o = 0.
  - inst_o, inst_addr_o and inst_c_o read 0.
  - rst overrides every other input.
- Flush (flush_i=1, rst=0):
  - Next cycle head = tail = count = 0.
  - Enqueue and dequeue in the same cycle are discarded.
  - ovf_o is unchanged; only rst clears it.
- Enqueue:
  - enq_req = number of consecutive ones in fb_en_i starting from bit 0.
  - Slots above the first zero are ignored. Example: 4'b1011 gives enq_req = 2.
  - Slot k is written to tail+k in slot order.
- Dequeue:
  - deq = min(deq_cnt_i, count), clamped. Head advances by deq.
- Simultaneous enqueue and dequeue:
  - capacity = DEPTH - count + deq.
  - enq = min(enq_req, capacity).
  - If enq_req > capacity: lowest slots are written, the excess is dropped, and ovf_o is set to 1 (sticky).
  - count_next = count - deq + enq. tail advances by enq.
- Outputs, combinational from registered state (0-cycle read):
  - valid_o[k] = (count > k).
  - Lane k shows entry head+k (mod DEPTH).
  - Invalid lanes drive 0 on inst_o, inst_addr_o and inst_c_o.
  - inst_c_o[k] = valid_o[k] and (inst_o[32k+1:32k] != 2'b11).
- Latency: an entry enqueued at edge N is visible on the lanes after edge N. There is no same-cycle bypass.
- full_o = (DEPTH - count) < SKID, combinational from registered count.
- Ordering is strict FIFO. Entries are never reordered or duplicated.

Test Plan:
- Reset, then idle: valid_o=00, count_o=0, full_o=0, ovf_o=0, all lane outputs 0.
- Enqueue fb_en_i=1111 with insts 0x00000001..4 at addresses 0x100/0x102/0x104/0x108, deq_cnt_i=0:
  - next cycle count_o=4, valid_o=11, lane0 = 0x00000001@0x100, lane1 = 0x00000002@0x102, inst_c_o=11.
  - then deq_cnt_i=2 gives lane0 = 0x00000003@0x104 and count_o=2.
- Wrap-around: 5 rounds of enqueue 4 / dequeue 4 with DEPTH=16. Output addresses stay strictly in enqueue order across the pointer wrap; count never exceeds 4.
- Threshold and overflow:
  - fill to count=8: full_o=0.
  - count=9: full_o=1.
  - at count=15, enqueue 4 with deq_cnt_i=2: 3 accepted (capacity 3), count_o=16, ovf_o=1.
  - ovf_o stays 1 through a later flush and clears only on rst.
- Flush priority: count=6, same cycle flush_i=1, fb_en_i=1111, deq_cnt_i=2. Next cycle count_o=0, valid_o=00. Enqueue resumes normally the following cycle.
- Edge inputs:
  - fb_en_i=1011 accepts exactly 2 entries.
  - deq_cnt_i=2 with count=1 removes 1 entry, and count_o=0.
  - a 32-bit inst 0x00000013 shows inst_c_o[0]=0.
